gppm_seq: RTL
=============

Name: gppm_seq

Overview:
Program sequencer that sits directly upstream of the GPPM datapath (register file + ALU). It fetches 32-bit instruction words from an external synchronous instruction ROM and decodes them into GPPM control fields. It branches on GPPM's isZero and captures GPPM's outrdata1 for OUT instructions. One program runs per start pulse until HALT.

Parameters:
PC_W, 8, program counter / imem address width (program space 2^PC_W words)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution at pc=0 when idle or halted
busy  out  1  high while executing
halted  out  1  high after HALT or illegal opcode until next start
err  out  1  high when halted by an illegal opcode
imem_addr  out  PC_W  ROM read address
imem_data  in  32  ROM read data, valid 1 cycle after imem_addr
raddr1  out  4  to GPPM
raddr2  out  4  to GPPM
wen  out  1  to GPPM
waddr  out  4  to GPPM
wdsrc  out  1  to GPPM (1=ALU result, 0=constant)
func  out  4  to GPPM
constant  out  32  to GPPM
alusrc  out  1  to GPPM (1=aluconst)
aluconst  out  32  to GPPM
isZero  in  1  from GPPM
outrdata1  in  32  from GPPM
out_data  out  32  captured outrdata1
out_valid  out  1  one-cycle pulse with out_data

Behaviour:
- Instruction fields: op=[31:28], rd=[27:24], rs1=[23:20], rs2=[19:16], fn=[15:12], imm12=[11:0], tgt=[PC_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LI: next word is the 32-bit immediate; rd<=imm.
  - 2 ALU: rd<=rs1 fn rs2.
  - 3 ALUI: rd<=rs1 fn sext(imm12).
  - 4 BZ: evaluate rs1 fn rs2; pc<=tgt if isZero.
  - 5 BNZ: as BZ, branch if !isZero.
  - 6 JMP: pc<=tgt.
  - 7 OUT: out_data<=outrdata1 (raddr1=rs1).
  - F HALT.
  - 8-E illegal: halt with err=1.
- States:
  - IDLE: on start go to FETCH.
  - FETCH: imem_addr=pc.
  - LOAD: ir<=imem_data, pc<=pc+1.
  - EXEC.
  - IMM_FETCH, IMM_LOAD (imm<=imem_data, pc<=pc+1), IMM_EXEC.
  - HALT.
- Transitions:
  - EXEC goes to FETCH, except: LI goes to IMM_FETCH; HALT/illegal goes to HALT.
  - IMM_EXEC goes to FETCH.
  - HALT on start: pc<=0, err<=0, go to FETCH.
- CPI: 3 cycles; LI takes 6.
- Control decode is combinational from ir, imm and state.
  - raddr1=rs1, raddr2=rs2, func=fn, waddr=rd at all times.
  - aluconst = sext(ir[11:0]).
  - constant = imm.
  - alusrc=1 only for ALUI.
  - wdsrc=0 only for LI.
- wen=1 for exactly one cycle:
  - in EXEC for ALU/ALUI;
  - in IMM_EXEC for LI;
  - 0 in every other state/op.
- isZero is sampled in EXEC of BZ/BNZ; the branch updates pc at the end of EXEC, overriding the increment already done in LOAD.
- OUT: out_data registered at end of EXEC; out_valid high the following cycle for one cycle.
- pc wraps 2^PC_W-1 -> 0 with no error; the immediate fetch also wraps.
- start while busy is ignored. busy=1 in FETCH..IMM_EXEC. halted=1 only in HALT.
- Reset (async, any state): state=IDLE; pc, ir, imm, out_data = 0; out_valid, err = 0; wen drops immediately. All control outputs are 0 after reset (ir=0).

Decomposition:
- Package gppm_pkg: opcode localparams (OP_NOP..OP_HALT), state enum, field bit positions, ALU func codes shared with GPPM/ALU.
- One sub-module: gppm_decode (combinational ir/state -> GPPM control outputs). FSM, pc and ir stay in gppm_seq.

Test Plan:
- Reset mid-LI (assert rst_n=0 in IMM_LOAD) -> wen=0 immediately; after release busy=0, pc=0, all outputs 0; start reruns from 0.
- ROM {LI r1,0x12345678; OUT r1; HALT} with GPPM model -> single wen in IMM_EXEC (waddr=1, wdsrc=0, constant=0x12345678); out_valid pulse with out_data=0x12345678; halted=1 at cycle 12 after start.
- ALUI r2,r1,ADD,imm12=0xFFF -> aluconst=0xFFFFFFFF, alusrc=1, wdsrc=1, wen one cycle.
- Countdown loop {LI r1,3; ALUI r1,r1,SUB,1; BNZ r1,r0,SUB,addr2; HALT} -> BNZ taken 2x, falls through 3rd; exactly 3 ALUI writes; halted.
- Opcode 0x9 at addr 0 -> halted=1, err=1, wen never asserted; next start clears err.
- PC_W=4, JMP 15 where word 15 is NOP and word 0 is HALT -> pc wraps 15->0, halts; start during busy has no effect.

Source files
------------

// File: rtl/gppm_pkg.sv
// Shared definitions for the GPPM program sequencer: opcodes, instruction
// field positions, ALU function codes understood by the GPPM ALU, and the
// sequencer state encoding.
package gppm_pkg;

    localparam int unsigned INSN_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned FN_W    = 4;
    localparam int unsigned IMM12_W = 12;

    // Instruction field LSB positions
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned RD_LSB  = 24;
    localparam int unsigned RS1_LSB = 20;
    localparam int unsigned RS2_LSB = 16;
    localparam int unsigned FN_LSB  = 12;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP  = 4'h0;
    localparam op_t OP_LI   = 4'h1;
    localparam op_t OP_ALU  = 4'h2;
    localparam op_t OP_ALUI = 4'h3;
    localparam op_t OP_BZ   = 4'h4;
    localparam op_t OP_BNZ  = 4'h5;
    localparam op_t OP_JMP  = 4'h6;
    localparam op_t OP_OUT  = 4'h7;
    localparam op_t OP_HALT = 4'hF;

    // ALU function codes shared with the GPPM ALU
    localparam logic [FN_W-1:0] FN_ADD = 4'h0;
    localparam logic [FN_W-1:0] FN_SUB = 4'h1;
    localparam logic [FN_W-1:0] FN_AND = 4'h2;
    localparam logic [FN_W-1:0] FN_OR  = 4'h3;
    localparam logic [FN_W-1:0] FN_XOR = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_EXEC      = 3'd3,
        ST_IMM_FETCH = 3'd4,
        ST_IMM_LOAD  = 3'd5,
        ST_IMM_EXEC  = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    // Opcodes 8..E are reserved and halt the sequencer with an error
    function automatic logic is_legal(input op_t op);
        return (op <= OP_OUT) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/gppm_decode.sv
// Combinational decode of the held instruction word (and LI immediate) into
// GPPM control fields.
// Ports: state/ir/imm in; raddr1, raddr2, waddr, func, wen, wdsrc, constant,
// alusrc, aluconst out.
module gppm_decode
    import gppm_pkg::*;
(
    input  state_t              state,
    input  logic [INSN_W-1:0]   ir,
    input  logic [INSN_W-1:0]   imm,
    output logic [REG_AW-1:0]   raddr1,
    output logic [REG_AW-1:0]   raddr2,
    output logic                wen,
    output logic [REG_AW-1:0]   waddr,
    output logic                wdsrc,
    output logic [FN_W-1:0]     func,
    output logic [INSN_W-1:0]   constant,
    output logic                alusrc,
    output logic [INSN_W-1:0]   aluconst
);

    op_t op;

    always_comb begin
        op       = ir[OP_LSB +: OP_W];
        raddr1   = ir[RS1_LSB +: REG_AW];
        raddr2   = ir[RS2_LSB +: REG_AW];
        waddr    = ir[RD_LSB +: REG_AW];
        func     = ir[FN_LSB +: FN_W];
        aluconst = {{(INSN_W-IMM12_W){ir[IMM12_W-1]}}, ir[IMM12_W-1:0]};
        constant = imm;
        alusrc   = (op == OP_ALUI);
        // Held low in IDLE so every control output is zero out of reset
        wdsrc    = (state != ST_IDLE) && (op != OP_LI);
        // Only LI reaches IMM_EXEC, so that state alone marks its write
        wen      = ((state == ST_EXEC) && ((op == OP_ALU) || (op == OP_ALUI)))
                 || (state == ST_IMM_EXEC);
    end

endmodule

// File: rtl/gppm_seq.sv
// GPPM program sequencer: fetches instructions from a synchronous ROM,
// decodes them into GPPM controls, branches on isZero, captures OUT data.
// Ports: clk, rst_n, start in; busy, halted, err status out; imem_addr out /
// imem_data in; GPPM control outs; isZero/outrdata1 in; out_data/out_valid out.
module gppm_seq
    import gppm_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSN_W-1:0]   imem_data,
    output logic [REG_AW-1:0]   raddr1,
    output logic [REG_AW-1:0]   raddr2,
    output logic                wen,
    output logic [REG_AW-1:0]   waddr,
    output logic                wdsrc,
    output logic [FN_W-1:0]     func,
    output logic [INSN_W-1:0]   constant,
    output logic                alusrc,
    output logic [INSN_W-1:0]   aluconst,
    input  logic                isZero,
    input  logic [INSN_W-1:0]   outrdata1,
    output logic [INSN_W-1:0]   out_data,
    output logic                out_valid
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [INSN_W-1:0]   ir_q, imm_q, out_data_q;
    logic                out_valid_q, err_q;
    op_t                 op;
    logic [PC_W-1:0]     tgt;

    assign op  = ir_q[OP_LSB +: OP_W];
    assign tgt = ir_q[PC_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_LI)                           state_d = ST_IMM_FETCH;
                else if ((op == OP_HALT) || !is_legal(op)) state_d = ST_HALT;
                else                                       state_d = ST_FETCH;
            end
            ST_IMM_FETCH: state_d = ST_IMM_LOAD;
            ST_IMM_LOAD:  state_d = ST_IMM_EXEC;
            ST_IMM_EXEC:  state_d = ST_FETCH;
            ST_HALT:      if (start) state_d = ST_FETCH;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_HALT: halted = 1'b1;
            default: busy   = 1'b1;
        endcase
    end

    // pc, instruction/immediate registers, OUT capture and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            ir_q        <= '0;
            imm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) pc_q <= '0;
                ST_LOAD: begin
                    ir_q <= imem_data;
                    pc_q <= pc_q + PC_W'(1);
                end
                ST_EXEC: begin
                    // Branch target overrides the increment done in LOAD
                    case (op)
                        OP_BZ:  if (isZero)  pc_q <= tgt;
                        OP_BNZ: if (!isZero) pc_q <= tgt;
                        OP_JMP: pc_q <= tgt;
                        OP_OUT: begin
                            out_data_q  <= outrdata1;
                            out_valid_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (!is_legal(op)) err_q <= 1'b1;
                end
                ST_IMM_LOAD: begin
                    imm_q <= imem_data;
                    pc_q  <= pc_q + PC_W'(1);
                end
                ST_HALT: begin
                    if (start) begin
                        pc_q  <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

    gppm_decode u_decode (
        .state    (state_q),
        .ir       (ir_q),
        .imm      (imm_q),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .wen      (wen),
        .waddr    (waddr),
        .wdsrc    (wdsrc),
        .func     (func),
        .constant (constant),
        .alusrc   (alusrc),
        .aluconst (aluconst)
    );

endmodule
